sparse_expand: RTL

SPARSE_EXPAND -- requirements
Module: sparse_expand

---
 rtl/sparse_expand_pkg.sv | 22 ++
 rtl/popcount_slice.sv | 23 ++
 rtl/sparse_expand.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sparse_expand_pkg.sv
// Shared SPRING sparsity definitions: element format, window geometry and the
// expander state encoding. post_sparsity also uses this package.
package sparse_expand_pkg;

  localparam int unsigned SpIl     = 4;
  localparam int unsigned SpFl     = 16;
  localparam int unsigned SpLength = 32;
  localparam int unsigned SpLanes  = 4;

  // Number of compressed values carried per block.
  localparam int unsigned NumVals = 16;
  localparam int unsigned ValIdxW = $clog2(NumVals);

  typedef logic signed [SpIl+SpFl-1:0] elem_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StEmit = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/popcount_slice.sv
// Popcount of one small mask slice: exclusive prefix count per bit plus total.
module popcount_slice #(
  parameter int unsigned LANES = 4,
  parameter int unsigned CW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]         slice,
  output logic [LANES-1:0][CW-1:0] prefix,
  output logic [CW-1:0]            total
);

  logic [CW-1:0] acc;

  // Running sum: prefix[l] counts set bits strictly below bit l.
  always_comb begin
    acc = '0;
    for (int l = 0; l < LANES; l++) begin
      prefix[l] = acc;
      acc       = acc + CW'(slice[l]);
    end
    total = acc;
  end

endmodule

// File: rtl/sparse_expand.sv
// Expands a compressed block (values + occupancy mask) back to a dense window,
// LANES elements per beat, with consumer backpressure.
module sparse_expand
  import sparse_expand_pkg::*;
#(
  parameter int unsigned IL     = SpIl,
  parameter int unsigned FL     = SpFl,
  parameter int unsigned length = SpLength,
  parameter int unsigned LANES  = SpLanes
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [IL+FL-1:0]   i_im [NumVals],
  input  logic [length-1:0]         i_mask,
  input  logic                      input_ready,
  input  logic                      output_taken,
  output logic signed [IL+FL-1:0]   o_dense [LANES],
  output logic                      o_valid,
  output logic [2:0]                o_beat,
  output logic                      o_overflow,
  output logic                      o_done,
  output logic [1:0]                state
);

  localparam int unsigned W     = IL + FL;
  localparam int unsigned NB    = length / LANES;
  localparam int unsigned BIdxW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned PtrW  = $clog2(length + 1);
  localparam int unsigned CW    = $clog2(LANES + 1);

  state_e                      state_q, state_d;
  logic [2:0]                  beat_q, beat_d;
  logic [PtrW-1:0]             ptr_q, ptr_d;
  logic                        ovf_q;
  logic [NB-1:0][LANES-1:0]    mask_q;
  logic signed [W-1:0]         im_q [NumVals];
  logic                        load;
  logic [PtrW-1:0]             in_cnt;
  logic [LANES-1:0]            slice;
  logic [LANES-1:0][CW-1:0]    prefix;
  logic [CW-1:0]               slice_total;
  logic [PtrW-1:0]             rank [LANES];

  assign slice = mask_q[beat_q[BIdxW-1:0]];

  popcount_slice #(
    .LANES (LANES),
    .CW    (CW)
  ) u_popcount_slice (
    .slice  (slice),
    .prefix (prefix),
    .total  (slice_total)
  );

  // Whole-mask popcount, only needed once per block for the overflow flag.
  always_comb begin
    in_cnt = '0;
    for (int i = 0; i < int'(length); i++) begin
      in_cnt = in_cnt + PtrW'(i_mask[i]);
    end
  end

  // Next-state: accept in IDLE, step beats on take, single-cycle DONE.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ptr_d   = ptr_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (input_ready) begin
          load    = 1'b1;
          state_d = StEmit;
          beat_d  = '0;
          ptr_d   = '0;
        end
      end
      StEmit: begin
        if (output_taken) begin
          // Pointer advances by the ones consumed in this beat's slice.
          ptr_d = ptr_q + PtrW'(slice_total);
          if (beat_q == 3'(NB - 1)) begin
            state_d = StDone;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        beat_d  = '0;
        ptr_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and block registers; reset discards any block in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      beat_q  <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      mask_q  <= '0;
      for (int i = 0; i < int'(NumVals); i++) begin
        im_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ptr_q   <= ptr_d;
      if (load) begin
        ovf_q  <= (in_cnt > PtrW'(NumVals));
        mask_q <= i_mask;
        for (int i = 0; i < int'(NumVals); i++) begin
          im_q[i] <= i_im[i];
        end
      end
    end
  end

  // Lane select: ranks beyond the stored values read as zero.
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      rank[l]    = ptr_q + PtrW'(prefix[l]);
      o_dense[l] = '0;
      if (state_q == StEmit && slice[l] && rank[l] < PtrW'(NumVals)) begin
        o_dense[l] = im_q[rank[l][ValIdxW-1:0]];
      end
    end
  end

  assign o_valid    = (state_q == StEmit);
  assign o_done     = (state_q == StDone);
  assign o_beat     = beat_q;
  assign o_overflow = ovf_q;
  assign state      = state_q;

endmodule
